// File: rtl/int_fp_mac_pkg.sv
// -----------------------------------------------------------------------------
// int_fp_mac_pkg
// Shared definitions for the INT/FP MAC datapath. It holds the FP16 field
// widths, the special-value constants, the mode encoding and the FP16 field
// struct.
// Ports: none (package).
// -----------------------------------------------------------------------------
package int_fp_mac_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;

  typedef enum logic {
    MODE_INT = 1'b0,
    MODE_FP  = 1'b1
  } mode_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp16_round_norm.sv
// -----------------------------------------------------------------------------
// fp16_round_norm
// This block normalises the 22-bit significand product. It rounds the product
// to FP16 with round-to-nearest-even, handles overflow and underflow, and packs
// the special values (NaN, Inf, zero).
// Build option INT_FP_MUL_SUBNORM_EN: when it is defined, results below the
// normal range are denormalised and rounded. When it is not defined, those
// results flush to signed zero.
// Ports:
//   sign_i     result sign (s1 ^ s2)
//   nan_i      product is NaN (any NaN input, or 0 x Inf)
//   inf_i      an operand is Inf (and the product is not NaN)
//   zero_i     an operand is zero (and the product is not NaN or Inf)
//   prod_i     significand product; value = prod_i * 2^-20 * 2^(exp_sum_i-15)
//   exp_sum_i  e1 + e2 - bias using effective exponents (signed)
//   result_o   packed FP16 result
//   error_o    NaN or overflow
// -----------------------------------------------------------------------------
module fp16_round_norm
  import int_fp_mac_pkg::*;
(
  input  logic                sign_i,
  input  logic                nan_i,
  input  logic                inf_i,
  input  logic                zero_i,
  input  logic [PROD_W-1:0]   prod_i,
  input  logic signed [7:0]   exp_sum_i,
  output logic [15:0]         result_o,
  output logic                error_o
);

  logic [4:0]          lead;
  logic [PROD_W-1:0]   norm;
  logic signed [9:0]   exp_n;
  logic signed [9:0]   exp_r;
  logic [SIG_W-1:0]    mant_n;
  logic [SIG_W:0]      mant_r;
  logic [FRAC_W-1:0]   frac_r;
  logic                tiny;
  logic [15:0]         tiny_res;

  // The position of the leading one places the binary point. For normal
  // operands it is at bit 20 or bit 21. Subnormal operands can put it lower.
  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < PROD_W; i++) begin
      if (prod_i[i]) lead = 5'(i);
    end
  end

  assign norm  = prod_i << (5'd21 - lead);
  assign exp_n = $signed({{2{exp_sum_i[7]}}, exp_sum_i}) + $signed({5'b0, lead}) - 10'sd20;

  // RNE at full precision, as if the exponent range had no lower limit
  assign mant_n = norm[21:11];
  assign mant_r = {1'b0, mant_n} + 12'(norm[10] & ((|norm[9:0]) | mant_n[0]));
  assign exp_r  = exp_n + $signed({9'b0, mant_r[11]});
  assign frac_r = mant_r[11] ? mant_r[10:1] : mant_r[9:0];

`ifdef INT_FP_MUL_SUBNORM_EN
  // Denormalise from the unrounded significand so rounding happens only once.
  // A shift of 31 already pushes every product bit below the guard position.
  logic signed [9:0]  sh_full;
  logic [4:0]         sh;
  logic [53:0]        wide;
  logic [SIG_W-1:0]   mant_s;
  logic [SIG_W-1:0]   mant_sr;

  assign sh_full = 10'sd1 - exp_n;
  assign sh      = (sh_full > 10'sd31) ? 5'd31 : sh_full[4:0];
  assign wide    = {norm, 32'b0} >> sh;
  assign mant_s  = wide[53:43];
  assign mant_sr = mant_s + 11'(wide[42] & ((|wide[41:0]) | mant_s[0]));
  assign tiny    = (exp_n < 10'sd1);
  // A rounding carry into bit 10 gives the smallest normal number (exponent 1)
  assign tiny_res = {sign_i, 4'b0, mant_sr[10], mant_sr[9:0]};
`else
  assign tiny     = (exp_r < 10'sd1);
  assign tiny_res = {sign_i, 15'b0};
`endif

  always_comb begin
    result_o = {sign_i, 15'b0};
    error_o  = 1'b0;
    if (nan_i) begin
      result_o = FP16_QNAN;
      error_o  = 1'b1;
    end else if (inf_i) begin
      result_o = {sign_i, FP16_PINF[14:0]};
    end else if (zero_i) begin
      result_o = {sign_i, 15'b0};
    end else if (exp_r >= 10'sd31) begin
      result_o = {sign_i, FP16_PINF[14:0]};
      error_o  = 1'b1;
    end else if (tiny) begin
      result_o = tiny_res;
    end else begin
      result_o = {sign_i, exp_r[4:0], frac_r};
    end
  end

endmodule

// File: rtl/int_fp_multiplier.sv
// -----------------------------------------------------------------------------
// int_fp_multiplier
// Dual-mode 16-bit multiplier. It sits ahead of the MAC accumulator. Mode 0 is
// a signed integer multiply with saturation. Mode 1 is an IEEE-754 binary16
// multiply. The outputs are registered one cycle after in_valid. result and
// error hold their values while in_valid is low.
// Build option INT_FP_MUL_SUBNORM_EN: when it is defined, subnormal inputs are
// used as operands and results can be subnormal. When it is not defined,
// subnormal inputs are treated as signed zero.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   in_valid         operands and mode are valid this cycle
//   mode             0 = signed int multiply, 1 = FP16 multiply
//   input1, input2   operands
//   out_valid        result/error are valid this cycle
//   result           16-bit product
//   error            saturation / NaN / FP overflow flag
// -----------------------------------------------------------------------------
module int_fp_multiplier
  import int_fp_mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mode,
  input  logic [15:0] input1,
  input  logic [15:0] input2,
  output logic        out_valid,
  output logic [15:0] result,
  output logic        error
);

  // Integer path
  logic signed [31:0] op1_x, op2_x, int_prod;
  logic               int_ovf;
  logic [15:0]        int_res;

  assign op1_x    = {{16{input1[15]}}, input1};
  assign op2_x    = {{16{input2[15]}}, input2};
  assign int_prod = op1_x * op2_x;
  // The product fits in 16 bits when bits 31..15 are all copies of the sign bit
  assign int_ovf  = ~((&int_prod[31:15]) | ~(|int_prod[31:15]));
  assign int_res  = int_ovf ? (int_prod[31] ? INT16_MIN : INT16_MAX) : int_prod[15:0];

  // FP16 operand decode
  fp16_t              fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0]   a_exp_eff, b_exp_eff;
  logic [SIG_W-1:0]   a_sig, b_sig;
  logic [PROD_W-1:0]  fp_prod;
  logic signed [7:0]  exp_sum;
  logic               fp_sign, fp_nan, fp_inf, fp_zero;
  logic [15:0]        fp_res;
  logic               fp_err;

  assign fa = input1;
  assign fb = input2;

  assign a_nan = (&fa.exp) & (|fa.frac);
  assign b_nan = (&fb.exp) & (|fb.frac);
  assign a_inf = (&fa.exp) & ~(|fa.frac);
  assign b_inf = (&fb.exp) & ~(|fb.frac);
`ifdef INT_FP_MUL_SUBNORM_EN
  assign a_zero = ~(|fa.exp) & ~(|fa.frac);
  assign b_zero = ~(|fb.exp) & ~(|fb.frac);
`else
  assign a_zero = ~(|fa.exp);
  assign b_zero = ~(|fb.exp);
`endif

  // A subnormal has implicit bit 0 and effective exponent 1. The leading-one
  // search in fp16_round_norm normalises it.
  assign a_sig     = {|fa.exp, fa.frac};
  assign b_sig     = {|fb.exp, fb.frac};
  assign a_exp_eff = (|fa.exp) ? fa.exp : 5'd1;
  assign b_exp_eff = (|fb.exp) ? fb.exp : 5'd1;
  assign fp_prod   = PROD_W'(a_sig) * PROD_W'(b_sig);
  assign exp_sum   = 8'({3'b0, a_exp_eff}) + 8'({3'b0, b_exp_eff}) - 8'(BIAS);

  assign fp_sign = fa.sign ^ fb.sign;
  assign fp_nan  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
  assign fp_inf  = a_inf | b_inf;
  assign fp_zero = a_zero | b_zero;

  fp16_round_norm u_round_norm (
    .sign_i    (fp_sign),
    .nan_i     (fp_nan),
    .inf_i     (fp_inf),
    .zero_i    (fp_zero),
    .prod_i    (fp_prod),
    .exp_sum_i (exp_sum),
    .result_o  (fp_res),
    .error_o   (fp_err)
  );

  // Output registers
  logic        out_valid_q, out_valid_d;
  logic [15:0] result_q, result_d;
  logic        error_q, error_d;

  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    error_d     = error_q;
    if (in_valid) begin
      if (mode_e'(mode) == MODE_FP) begin
        result_d = fp_res;
        error_d  = fp_err;
      end else begin
        result_d = int_res;
        error_d  = int_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
      error_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      error_q     <= error_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign error     = error_q;

endmodule

// File: tb/tb_int_fp_multiplier.sv
// -----------------------------------------------------------------------------
// tb_int_fp_multiplier
// Self-checking bench for int_fp_multiplier. The reference model computes FP16
// products from real-valued operands and applies RNE quantisation. It computes
// integer products with 64-bit arithmetic. A per-cycle compare process checks
// the DUT against this model. Literal expectations pin the model down.
// It follows INT_FP_MUL_SUBNORM_EN the same way the DUT does.
// -----------------------------------------------------------------------------
module tb_int_fp_multiplier;

`ifdef INT_FP_MUL_SUBNORM_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        mode;
  logic [15:0] input1, input2;
  logic        out_valid;
  logic [15:0] result;
  logic        error;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  int_fp_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .input1    (input1),
    .input2    (input2),
    .out_valid (out_valid),
    .result    (result),
    .error     (error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic real p2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic logic [16:0] int_ref(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (p > 32767)  return {1'b1, 16'h7FFF};
    if (p < -32768) return {1'b1, 16'h8000};
    return {1'b0, p[15:0]};
  endfunction

  // Returns {error, result}
  function automatic logic [16:0] fp_ref(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int   ea, eb, fa, fb, e, qi, fi;
    bit   na, nb, ia, ib, za, zb;
    real  va, vb, x, q, fr;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); fa = int'(a[9:0]);
    eb = int'(b[14:10]); fb = int'(b[9:0]);
    na = (ea == 31) && (fa != 0);  nb = (eb == 31) && (fb != 0);
    ia = (ea == 31) && (fa == 0);  ib = (eb == 31) && (fb == 0);
    za = (ea == 0) && ((fa == 0) || !SUB);
    zb = (eb == 0) && ((fb == 0) || !SUB);
    if (na || nb || (za && ib) || (ia && zb)) return {1'b1, 16'h7E00};
    if (ia || ib) return {1'b0, s, 15'h7C00};
    if (za || zb) return {1'b0, s, 15'h0000};
    va = (ea == 0) ? fa * p2(-24) : (1024 + fa) * p2(ea - 25);
    vb = (eb == 0) ? fb * p2(-24) : (1024 + fb) * p2(eb - 25);
    x  = va * vb;
    e = 0;
    while (x >= p2(e + 1)) e++;
    while (x < p2(e)) e--;
    if (SUB && e < -14) e = -14;
    q  = x / p2(e - 10);
    qi = $rtoi(q);
    fr = q - qi;
    if (fr > 0.5 || (fr == 0.5 && qi[0])) qi++;
    x = qi * p2(e - 10);
    if (x >= 65536.0) return {1'b1, s, 15'h7C00};
    if (x < p2(-14)) begin
      if (!SUB) return {1'b0, s, 15'h0000};
      return {1'b0, s, 5'b0, 10'(qi)};
    end
    e = -14;
    while (x >= p2(e + 1)) e++;
    fi = $rtoi(x / p2(e - 10)) - 1024;
    return {1'b0, s, 5'(e + 15), 10'(fi)};
  endfunction

  logic        m_valid = 1'b0;
  logic [15:0] m_res   = 16'h0;
  logic        m_err   = 1'b0;
  logic        m_mode  = 1'b0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_res   <= 16'h0;
      m_err   <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        {m_err, m_res} <= mode ? fp_ref(input1, input2) : int_ref(input1, input2);
        m_mode <= mode;
        m_a    <= input1;
        m_b    <= input2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (out_valid !== m_valid || result !== m_res || error !== m_err) begin
        miscompares++;
        $display("FAIL model t=%0t mode=%0b a=%h b=%h: got v=%0b r=%h e=%0b, want v=%0b r=%h e=%0b",
                 $time, m_mode, m_a, m_b, out_valid, result, error, m_valid, m_res, m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic m, input logic [15:0] a, input logic [15:0] b, input logic v);
    mode = m; input1 = a; input2 = b; in_valid = v;
  endtask

  task automatic lit_check(input string name, input logic v, input logic [15:0] r, input logic e);
    vectors++;
    if (out_valid !== v || result !== r || error !== e) begin
      miscompares++;
      $display("FAIL %s: got v=%0b r=%h e=%0b, want v=%0b r=%h e=%0b",
               name, out_valid, result, error, v, r, e);
    end
  endtask

  task automatic lit(input string name, input logic m, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] r, input logic e);
    @(negedge clk);
    drive(m, a, b, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    lit_check(name, 1'b1, r, e);
  endtask

  function automatic logic [15:0] gen_fp();
    logic [4:0] e;
    logic [9:0] f;
    f = 10'($urandom);
    e = 5'($urandom_range(6, 24));
    case ($urandom_range(0, 11))
      0: e = 5'd0;
      1: e = 5'd31;
      2: f = 10'd0;
      3: e = 5'($urandom);
      4: e = 5'($urandom_range(0, 3));
      5: begin e = 5'd31; f = 10'd0; end
      6: begin e = 5'd0;  f = 10'd0; end
      default: ;
    endcase
    return {1'($urandom), e, f};
  endfunction

  function automatic logic [15:0] gen_int();
    logic [15:0] bl [8];
    bl = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h00B5, 16'h00B6, 16'hFF4B};
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return bl[$urandom_range(0, 7)];
      2:       return 16'($urandom_range(0, 511)) - 16'd256;
      default: return 16'($urandom_range(0, 65535)) >> $urandom_range(4, 10);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h4000, 16'h0004, 1'b1);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    lit_check("reset", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);

    lit("int 3*-2",        1'b0, 16'h0003, 16'hFFFE, 16'hFFFA, 1'b0);
    lit("int pos sat",     1'b0, 16'h4000, 16'h0004, 16'h7FFF, 1'b1);
    lit("int -32768*-1",   1'b0, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1);
    lit("int neg sat",     1'b0, 16'h4000, 16'hFFFC, 16'h8000, 1'b1);
    lit("int -32768*1",    1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b0);
    lit("fp 1.5*2",        1'b1, 16'h3E00, 16'h4000, 16'h4200, 1'b0);
    lit("fp 1*-1",         1'b1, 16'h3C00, 16'hBC00, 16'hBC00, 1'b0);
    lit("fp 0*-0",         1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0);
    lit("fp overflow",     1'b1, 16'h7BFF, 16'h4000, 16'h7C00, 1'b1);
    lit("fp nan in",       1'b1, 16'h7E00, 16'h3C00, 16'h7E00, 1'b1);
    lit("fp 0*inf",        1'b1, 16'h0000, 16'h7C00, 16'h7E00, 1'b1);
    lit("fp -inf*2",       1'b1, 16'hFC00, 16'h4000, 16'hFC00, 1'b0);
    lit("fp rne",          1'b1, 16'h3C01, 16'h3C01, 16'h3C02, 1'b0);
    lit("fp subnormal",    1'b1, 16'h0001, 16'h3C00, SUB ? 16'h0001 : 16'h0000, 1'b0);
    lit("fp tiny flush",   1'b1, 16'h0400, 16'h3800, SUB ? 16'h0200 : 16'h0000, 1'b0);

    // back-to-back INT, FP, INT then hold
    @(negedge clk); drive(1'b0, 16'h0003, 16'hFFFE, 1'b1);
    @(negedge clk); drive(1'b1, 16'h3E00, 16'h4000, 1'b1);
    lit_check("b2b int0", 1'b1, 16'hFFFA, 1'b0);
    @(negedge clk); drive(1'b0, 16'h4000, 16'h0004, 1'b1);
    lit_check("b2b fp",   1'b1, 16'h4200, 1'b0);
    @(negedge clk); drive(1'b1, 16'h7E00, 16'h7E00, 1'b0);
    lit_check("b2b int1", 1'b1, 16'h7FFF, 1'b1);
    @(negedge clk);
    lit_check("hold0", 1'b0, 16'h7FFF, 1'b1);
    @(negedge clk);
    lit_check("hold1", 1'b0, 16'h7FFF, 1'b1);

    // reset in the middle of traffic discards the in-flight operation
    @(negedge clk); drive(1'b1, 16'h3C00, 16'h4000, 1'b1);
    @(negedge clk); rst = 1'b1; drive(1'b0, 16'h4000, 16'h0004, 1'b1);
    @(negedge clk);
    lit_check("reset mid", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1)
        drive(1'b1, gen_fp(), gen_fp(), $urandom_range(0, 9) < 8);
      else
        drive(1'b0, gen_int(), gen_int(), $urandom_range(0, 9) < 8);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_fp_multiplier.md
Name: int_fp_multiplier

Overview:
- Dual-mode 16-bit multiplier for the INT/FP MAC datapath.
- `mode` selects one of two operations:
  - signed 16-bit integer multiply with saturation;
  - IEEE-754 binary16 (FP16) multiply.
- Produces a 16-bit result and an error flag, registered one cycle after the operands are accepted.
- Sits ahead of the accumulator stage in the MAC.

Parameters:
- None. Data width is fixed at 16; latency is fixed at 1 cycle.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Synchronous reset, active-high.
- in_valid  input  1  Operands and mode are valid this cycle.
- mode  input  1  0 = signed integer multiply; 1 = FP16 multiply.
- input1  input  16  Operand A (two's complement, or FP16 {sign, exp[4:0], frac[9:0]}).
- input2  input  16  Operand B, same format as input1.
- out_valid  output  1  result/error are valid this cycle.
- result  output  16  Product.
- error  output  1  Exception flag for the product in result.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, result=16'h0000, error=0. Any in-flight operation is discarded.
- Latency and handshake:
  - Combinational multiply; output registers are loaded on a clk edge when in_valid=1.
  - out_valid is in_valid delayed by one cycle.
  - When in_valid=0, result and error hold their previous values.
  - No backpressure; a new operation can be accepted every cycle.
- INT mode (mode=0):
  - Full 32-bit signed product of input1 × input2.
  - If the product fits in [-32768, 32767]: result = product[15:0], error=0.
  - Otherwise: saturate to 16'h7FFF (positive overflow) or 16'h8000 (negative overflow), error=1.
  - Boundary case: -32768 × -1 gives 16'h7FFF with error=1.
- FP mode (mode=1), binary16, bias 15:
  - Sign = s1 XOR s2 for every result, including zero and infinity.
  - NaN: any NaN input, or 0 × Inf, gives canonical quiet NaN 16'h7E00 (sign 0), error=1.
  - Inf × finite nonzero gives signed Inf, error=0.
  - Zero × finite gives signed zero, error=0.
  - Normal path: 11×11-bit significand product; exponent = e1 + e2 - 15, adjusted after normalisation.
  - Rounding is round-to-nearest-even using guard and sticky bits.
  - Renormalise if rounding carries out of the significand.
  - Overflow (exponent ≥ 31 after rounding) gives signed Inf (16'h7C00 / 16'hFC00), error=1.
  - Underflow handling is governed by the Optional Feature. Underflow alone never sets error.

Optional Feature:
- Macro: INT_FP_MUL_SUBNORM_EN.
- Defined:
  - Subnormal inputs are used with implicit bit 0 and effective exponent 1, and are pre-normalised.
  - Results below the normal range are denormalised with RNE rounding, so results can be subnormal.
- Undefined:
  - Subnormal inputs are treated as signed zero.
  - Any result with exponent < 1 after rounding flushes to signed zero.

Decomposition:
- Shared package int_fp_mac_pkg holds:
  - FP16 field widths: EXP_W=5, FRAC_W=10, BIAS=15;
  - constants FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00, INT16_MAX=16'h7FFF, INT16_MIN=16'h8000;
  - mode encodings MODE_INT=0, MODE_FP=1.
- One natural sub-module, fp16_round_norm: normalisation, RNE rounding, overflow/underflow and special-value packing.
- The integer path and the output registers stay in the top module.

Test Plan:
- Reset: assert rst with in_valid=1 -> next cycle out_valid=0, result=0000, error=0.
- INT mode:
  - 0003 × FFFE -> FFFA, error=0 (one cycle later, out_valid=1).
  - 4000 × 0004 -> 7FFF, error=1.
  - 8000 × FFFF -> 7FFF, error=1.
- FP basic: 3E00 × 4000 (1.5×2) -> 4200; 3C00 × BC00 -> BC00; 0000 × 8000 -> 8000. All error=0.
- FP special cases: 7BFF × 4000 -> 7C00, error=1. 7E00 × 3C00 -> 7E00, error=1. 0000 × 7C00 -> 7E00, error=1.
- FP rounding: 3C01 × 3C01 -> 3C02 (RNE), error=0.
- Subnormals: 0001 × 3C00 -> 0001 with INT_FP_MUL_SUBNORM_EN, 0000 without; error=0 in both builds.
- Back-to-back: in_valid high for 3 consecutive cycles with INT, FP, INT operands -> three consecutive correct outputs. Dropping in_valid holds result and error.
